// File: rtl/lsu_ctrl.sv
// Load/store initiator: turns one byte-addressed pipeline request at a time into
// word accesses on a synchronous data memory, with sub-word extract/merge and fault checks.
module lsu_ctrl #(
    parameter int unsigned DEPTH = 41
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_signal,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        WR,
        RESP
    } state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [29:0] idx_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] data_q;     // store data, later the merged word for sub-word stores
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        accept;
    logic        fault_now;

    function automatic logic is_fault(input logic [31:0] addr, input logic [1:0] size);
        logic bad_align;
        bad_align = 1'b0;
        case (size)
            SIZE_BYTE: bad_align = 1'b0;
            SIZE_HALF: bad_align = addr[0];
            SIZE_WORD: bad_align = (addr[1:0] != 2'b00);
            default:   bad_align = 1'b1;
        endcase
        return bad_align | (addr[31:2] >= DEPTH_W);
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[7:0];
        case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: result = {{24{sgn & b[7]}}, b};
            SIZE_HALF: result = {{16{sgn & h[15]}}, h};
            default:   result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] result;
        result = word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0: result[7:0]   = data[7:0];
                    2'd1: result[15:8]  = data[7:0];
                    2'd2: result[23:16] = data[7:0];
                    2'd3: result[31:24] = data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) result[31:16] = data[15:0];
                else         result[15:0]  = data[15:0];
            end
            default: result = data;
        endcase
        return result;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign fault_now = is_fault(req_addr, req_size);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                fault_q <= fault_now;
                rdata_q <= '0;
            end
            if (state == RD_CAPT && !write_q) begin
                rdata_q <= extract(mem_read_data, lane_q, size_q, signed_q);
            end
        end
    end

    // NOTE: the request/datapath registers carry no reset; they are always
    // loaded at accept before any state reads them, so reset only costs routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= req_write;
            idx_q    <= req_addr[31:2];
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            data_q   <= req_wdata;
        end else if (state == RD_CAPT && write_q) begin
            data_q <= merge(mem_read_data, data_q, lane_q, size_q);
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_signal = 1'b0;
        resp_valid       = 1'b0;
        resp_fault       = 1'b0;
        resp_rdata       = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault_now)                           state_next = RESP;
                    else if (req_write && req_size == SIZE_WORD) state_next = WR;
                    else                                     state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                mem_address = {2'b00, idx_q};
                state_next  = RD_CAPT;
            end
            RD_CAPT: begin
                state_next = write_q ? WR : RESP;
            end
            WR: begin
                mem_address      = {2'b00, idx_q};
                mem_write_data   = data_q;
                mem_write_signal = 1'b1;
                state_next       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a request-level model predicts every cycle's outputs from
// the access rules and latency table, plus directed literal checks on key results.
module tb_lsu_ctrl;

    localparam int DEPTH = 41;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_signal;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    lsu_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_signal(mem_write_signal), .mem_read_data(mem_read_data)
    );

    // Synchronous data memory attached to the port.
    logic [31:0] dev_mem [0:63];
    always @(posedge clk) begin
        if (mem_write_signal) dev_mem[mem_address[5:0]] <= mem_write_data;
        mem_read_data <= dev_mem[mem_address[5:0]];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- request-level model ----------------
    function automatic bit m_is_fault(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] s, input bit sg);
        int sh;
        logic [31:0] v;
        sh = 8 * int'(a[1:0]);
        if (s == 2'b00) begin
            v = (w >> sh) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else if (s == 2'b01) begin
            v = (w >> sh) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] s);
        int sh;
        logic [31:0] mask;
        if (s == 2'b10) return d;
        sh = 8 * int'(a[1:0]);
        mask = ((s == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    function automatic int m_latency(input bit wr, input logic [1:0] s, input bit flt);
        if (flt) return 1;
        if (wr && s == 2'b10) return 2;
        if (!wr) return 3;
        return 4;
    endfunction

    logic [31:0] ref_mem [0:63];
    int          cyc = 0;
    bit          model_on = 1'b0;
    bit          busy = 1'b0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          m_lat;
    int          m_idx;
    bit          m_fault, m_wr, m_sg;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;

    // Observations of the DUT for directed checks.
    int          resp_cnt = 0;
    int          wr_cnt = 0;
    int          last_lat = 0;
    int          dut_acc_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    logic [31:0] last_wr_idx = '0;
    logic [31:0] last_wr_data = '0;

    always @(negedge clk) begin
        bit          cur_idle, e_resp, e_wr, e_rd;
        int          k;
        logic [31:0] e_addr, e_wdat;

        if (resp_valid) begin
            resp_cnt++;
            last_rdata = resp_rdata;
            last_fault = resp_fault;
            last_lat   = cyc - acc_cyc;
        end
        if (mem_write_signal) begin
            wr_cnt++;
            last_wr_idx  = mem_address;
            last_wr_data = mem_write_data;
        end
        if (req_valid && req_ready && !reset) dut_acc_cyc = cyc;

        cur_idle = !busy;
        if (model_on) begin
            k      = cyc - acc_cyc;
            e_resp = busy && k == m_lat;
            e_wr   = busy && m_wr && !m_fault && k == m_lat - 1;
            e_rd   = busy && !m_fault && !(m_wr && m_size == 2'b10) && k == 1;
            e_addr = (e_wr || e_rd) ? 32'(m_idx) : 32'h0;
            check("req_ready", 32'(req_ready), 32'(cur_idle));
            check("resp_valid", 32'(resp_valid), 32'(e_resp));
            check("mem_write_signal", 32'(mem_write_signal), 32'(e_wr));
            check("mem_address", mem_address, e_addr);
            if (e_wr) begin
                e_wdat = m_merge(ref_mem[m_idx], m_wdata, m_addr, m_size);
                check("mem_write_data", mem_write_data, e_wdat);
                ref_mem[m_idx] = e_wdat;
            end
            if (e_resp) begin
                check("resp_fault", 32'(resp_fault), 32'(m_fault));
                check("resp_rdata", resp_rdata, m_rdata);
                busy = 1'b0;
            end
        end

        if (reset) begin
            model_on = 1'b1;
            busy     = 1'b0;
        end else if (model_on && cur_idle && req_valid) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            acc_cnt++;
            m_wr    = req_write;
            m_addr  = req_addr;
            m_size  = req_size;
            m_sg    = req_signed;
            m_wdata = req_wdata;
            m_fault = m_is_fault(req_addr, req_size);
            m_lat   = m_latency(req_write, req_size, m_fault);
            m_idx   = m_fault ? 0 : int'(req_addr >> 2);
            m_rdata = (!m_wr && !m_fault) ? m_load(ref_mem[m_idx], m_addr, m_size, m_sg) : 32'h0;
        end
        cyc++;
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit w, input logic [31:0] a, input logic [1:0] s,
                         input bit sg, input logic [31:0] d);
        req_write  = w;
        req_addr   = a;
        req_size   = s;
        req_signed = sg;
        req_wdata  = d;
        req_valid  = 1'b1;
    endtask

    task automatic wait_acc(input int a0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (acc_cnt != a0);
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'h1);
    endtask

    task automatic wait_resp(input int r0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (resp_cnt != r0);
        end
        if (!ok) check("resp_timeout", 32'(ok), 32'h1);
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [1:0] s,
                          input bit sg, input logic [31:0] d);
        int a0, r0;
        a0 = acc_cnt;
        r0 = resp_cnt;
        @(posedge clk); #1;
        drive(w, a, s, sg, d);
        wait_acc(a0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(r0);
    endtask

    task automatic expect_resp(input string name, input logic [31:0] rdata,
                               input bit fault, input int lat);
        check({name, "_rdata"}, last_rdata, rdata);
        check({name, "_fault"}, 32'(last_fault), 32'(fault));
        check({name, "_lat"}, 32'(last_lat), 32'(lat));
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sg;
        logic [31:0] exp;
    } load_vec_t;

    typedef struct {
        string       name;
        bit          w;
        logic [31:0] addr;
        logic [1:0]  size;
    } fault_vec_t;

    load_vec_t  loads [4];
    fault_vec_t faults [4];

    initial begin
        int w0, r0, c1, c2, a0;

        loads[0] = '{"lb_s_13",  32'h13, 2'b00, 1'b1, 32'hFFFFFFDE};
        loads[1] = '{"lbu_13",   32'h13, 2'b00, 1'b0, 32'h000000DE};
        loads[2] = '{"lh_s_10",  32'h10, 2'b01, 1'b1, 32'hFFFFBEEF};
        loads[3] = '{"lhu_12",   32'h12, 2'b01, 1'b0, 32'h0000DEAD};
        faults[0] = '{"f_lw_12",  1'b0, 32'h12, 2'b10};
        faults[1] = '{"f_sh_11",  1'b1, 32'h11, 2'b01};
        faults[2] = '{"f_size3",  1'b0, 32'h10, 2'b11};
        faults[3] = '{"f_lw_a4",  1'b0, 32'hA4, 2'b10};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_mem_we", 32'(mem_write_signal), 32'h0);
        check("rst_mem_addr", mem_address, 32'h0);

        // Word store then word load.
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        expect_resp("sw_10", 32'h0, 1'b0, 2);
        check("sw_10_idx", last_wr_idx, 32'd4);
        check("sw_10_data", last_wr_data, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        expect_resp("lw_10", 32'hDEADBEEF, 1'b0, 3);

        foreach (loads[i]) begin
            do_req(1'b0, loads[i].addr, loads[i].size, loads[i].sg, 32'h0);
            expect_resp(loads[i].name, loads[i].exp, 1'b0, 3);
        end

        // Sub-word store: read-modify-write.
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h00000055);
        expect_resp("sb_11", 32'h0, 1'b0, 4);
        check("sb_11_data", last_wr_data, 32'hDEAD55EF);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        expect_resp("lw_after_sb", 32'hDEAD55EF, 1'b0, 3);

        // Faults never touch memory.
        foreach (faults[i]) begin
            w0 = wr_cnt;
            do_req(faults[i].w, faults[i].addr, faults[i].size, 1'b0, 32'hFFFFFFFF);
            expect_resp(faults[i].name, 32'h0, 1'b1, 1);
            check({faults[i].name, "_nowrite"}, 32'(wr_cnt), 32'(w0));
        end

        // Highest valid word index.
        do_req(1'b1, 32'hA0, 2'b10, 1'b0, 32'hCAFEF00D);
        expect_resp("sw_a0", 32'h0, 1'b0, 2);
        check("sw_a0_idx", last_wr_idx, 32'd40);
        do_req(1'b0, 32'hA0, 2'b10, 1'b0, 32'h0);
        expect_resp("lw_a0", 32'hCAFEF00D, 1'b0, 3);

        // Reset during RD_CAPT of a half store abandons it.
        a0 = acc_cnt;
        @(posedge clk); #1;
        drive(1'b1, 32'h10, 2'b01, 1'b0, 32'h00001234);
        wait_acc(a0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        w0 = wr_cnt;
        r0 = resp_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_nowrite", 32'(wr_cnt), 32'(w0));
        check("rst_mid_noresp", 32'(resp_cnt), 32'(r0));
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        expect_resp("lw_after_rst", 32'hDEAD55EF, 1'b0, 3);

        // req_valid held high across two requests.
        a0 = acc_cnt;
        r0 = resp_cnt;
        @(posedge clk); #1;
        drive(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344);
        wait_acc(a0);
        c1 = dut_acc_cyc;
        @(posedge clk); #1;
        drive(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        wait_acc(a0 + 1);
        c2 = dut_acc_cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(r0 + 1);
        check("b2b_gap", 32'(c2 - c1), 32'd3);
        expect_resp("b2b_lw", 32'h11223344, 1'b0, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the processor pipeline and the word-addressed data memory.
- Accepts one byte-addressed load or store at a time from the pipeline. Converts it to word accesses on the memory port and returns a response.
- Handles byte and halfword accesses: sign or zero extension on loads, read-modify-write on sub-word stores.
- Flags misaligned and out-of-range accesses as faults; a faulting access never touches memory.

Parameters:
- DEPTH, 41, number of 32-bit words in the attached data memory; valid word index is 0..DEPTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (faults)
- req_signed  in  1  load sign-extends when 1
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid
- mem_address  out  32  word index to memory
- mem_write_data  out  32  word to write
- mem_write_signal  out  1  memory write enable
- mem_read_data  in  32  memory read data; registered by memory on the edge that sampled mem_address with mem_write_signal=0

Behaviour:
- Reset:
  - synchronous, active-high, on clk.
  - state <= IDLE; resp_valid, resp_fault = 0; resp_rdata = 0.
  - mem_write_signal = 0, mem_address = 0, mem_write_data = 0.
  - Reset mid-operation abandons the access: no write issued, no response.
- Accept:
  - req_valid & req_ready at a rising edge latches write, addr, size, signed and wdata.
  - idx = addr[31:2]; lane = addr[1:0].
- Fault check at accept:
  - size 11 faults.
  - half with addr[0]=1 faults.
  - word with addr[1:0]!=0 faults.
  - idx >= DEPTH faults.
  - Fault -> RESP with resp_fault=1, resp_rdata=0.
- States:
  - IDLE: req_ready=1, mem_write_signal=0.
    - Accept with no fault -> WR if word store.
    - Accept with no fault -> RD_ISSUE otherwise (loads, sub-word stores).
    - No accept: stay.
  - RD_ISSUE: mem_address=idx, mem_write_signal=0 -> RD_CAPT.
  - RD_CAPT: mem_read_data valid.
    - Load: resp_rdata <= extract(mem_read_data) -> RESP.
    - Store: merged <= mem_read_data with the target lane(s) replaced by wdata -> WR.
  - WR: mem_address=idx, mem_write_data=merged (or wdata for word stores), mem_write_signal=1 for exactly this cycle -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. No response backpressure.
- Extraction (little-endian):
  - Byte lane n = word[8n+7:8n].
  - Half lane = addr[1] (0 -> [15:0], 1 -> [31:16]).
  - Sign-extend if signed, else zero-extend. Word returned as-is.
- Latency, counted from the accept edge T; resp_valid high in the cycle after edge:
  - fault: T+1
  - word store: T+2
  - load: T+3
  - sub-word store: T+4
- req_ready is 0 from the accept edge until the cycle after RESP. Back-to-back requests are accepted only in IDLE.
- mem_address is held at 0 whenever not in RD_ISSUE or WR.
- mem_write_signal is never high in any state other than WR.

Test Plan:
- Reset, then word store addr 0x10, wdata 0xDEADBEEF -> write pulse at idx 4, resp_valid at T+2, fault=0; word load addr 0x10 -> resp_rdata 0xDEADBEEF at T+3.
- With mem[4]=0xDEADBEEF:
  - signed byte load addr 0x13 -> 0xFFFFFFDE.
  - unsigned byte load addr 0x13 -> 0x000000DE.
  - signed half load addr 0x10 -> 0xFFFFBEEF.
  - unsigned half load addr 0x12 -> 0x0000DEAD.
- Byte store addr 0x11, wdata 0x55, over mem[4]=0xDEADBEEF -> read at RD_ISSUE, then write 0xDEAD55EF; resp at T+4.
- Faults, each giving resp_fault=1 at T+1, resp_rdata=0, mem_write_signal never asserted:
  - word load addr 0x12
  - half store addr 0x11
  - size 11
  - word load addr 0xA4 (idx 41)
- Reset asserted during RD_CAPT of a half store -> state IDLE next cycle, no write pulse, no resp_valid, req_ready=1.
- req_valid held high across two requests -> second accepted only in IDLE after the first RESP; req_ready=0 throughout the busy period.
